// File: rtl/ps2_init_sequencer.sv
// ============================================================================
//  Module   : ps2_init_sequencer
//  Brief    : PS/2 mouse init sequencer (reset, BAT/ID, sample rate, stream
//             enable) with retry/timeouts, plus 3-byte movement packet framer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_init_sequencer #(
  parameter int SAMPLE_RATE = 100,
  parameter int ACK_TIMEOUT = 1_000_000,
  parameter int BAT_TIMEOUT = 40_000_000,
  parameter int PKT_GAP     = 100_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       start,
  output logic       tx_valid,
  output logic [7:0] tx_byte,
  input  logic       tx_ready,
  input  logic       tx_error,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       busy,
  output logic       ready,
  output logic       error,
  output logic [2:0] err_code,
  output logic       pkt_valid,
  output logic [2:0] pkt_buttons,
  output logic [8:0] pkt_dx,
  output logic [8:0] pkt_dy,
  output logic [1:0] pkt_ovf
);

  localparam int TMAX_CYC = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
  localparam int TW       = $clog2(TMAX_CYC + 1);
  localparam int GW       = $clog2(PKT_GAP + 1);
  localparam int RW       = $clog2(MAX_RETRY + 2);

  localparam logic [TW-1:0] ACK_LIM   = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] BAT_LIM   = TW'(BAT_TIMEOUT);
  localparam logic [GW-1:0] GAP_LIM   = GW'(PKT_GAP);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [7:0]    RATE_BYTE = 8'(SAMPLE_RATE);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_ACK = 3'd2,
    WAIT_BAT = 3'd3,
    WAIT_ID  = 3'd4,
    RUN      = 3'd5,
    ERROR    = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    step_q, step_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d, timer_inc;
  logic [GW-1:0] gap_q, gap_d;
  logic          error_q, error_d;
  logic [2:0]    err_code_q, err_code_d;
  logic [1:0]    idx_q, idx_d, idx_eff;
  logic [7:0]    b0_q, b0_d, b1_q, b1_d;
  logic          pkt_valid_q, pkt_valid_d;
  logic [2:0]    pkt_buttons_q, pkt_buttons_d;
  logic [8:0]    pkt_dx_q, pkt_dx_d, pkt_dy_q, pkt_dy_d;
  logic [1:0]    pkt_ovf_q, pkt_ovf_d;
  logic          fail;
  logic [2:0]    fail_code;
  logic [7:0]    rom_byte;

  always_comb begin
    case (step_q)
      2'd0:    rom_byte = 8'hFF;
      2'd1:    rom_byte = 8'hF3;
      2'd2:    rom_byte = RATE_BYTE;
      default: rom_byte = 8'hF4;
    endcase
  end

  assign timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;
  // A partially received packet is abandoned once the inter-byte gap expires.
  assign idx_eff   = (idx_q != 2'd0 && gap_q >= GAP_LIM) ? 2'd0 : idx_q;

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    retry_d       = retry_q;
    timer_d       = timer_q;
    gap_d         = gap_q;
    error_d       = error_q;
    err_code_d    = err_code_q;
    idx_d         = idx_q;
    b0_d          = b0_q;
    b1_d          = b1_q;
    pkt_valid_d   = 1'b0;
    pkt_buttons_d = pkt_buttons_q;
    pkt_dx_d      = pkt_dx_q;
    pkt_dy_d      = pkt_dy_q;
    pkt_ovf_d     = pkt_ovf_q;
    fail          = 1'b0;
    fail_code     = 3'd0;

    case (state_q)
      SEND: begin
        if (tx_error) begin
          fail = 1'b1; fail_code = 3'd4;
        end else if (tx_ready) begin
          state_d = WAIT_ACK;
          timer_d = '0;
        end
      end
      WAIT_ACK: begin
        timer_d = timer_inc;
        if (tx_error) begin
          fail = 1'b1; fail_code = 3'd4;
        end else if (rx_valid) begin
          if (rx_byte == 8'hFA) begin
            if (step_q == 2'd0) begin
              state_d = WAIT_BAT;
              timer_d = '0;
            end else if (step_q == 2'd3) begin
              state_d = RUN;
              idx_d   = 2'd0;
              gap_d   = '0;
            end else begin
              state_d = SEND;
              step_d  = step_q + 2'd1;
            end
          end else if (rx_byte == 8'hFE && retry_q < RETRY_MAX) begin
            state_d = SEND;
            retry_d = retry_q + 1'b1;
          end else begin
            fail = 1'b1; fail_code = 3'd2;
          end
        end else if (timer_q >= ACK_LIM) begin
          fail = 1'b1; fail_code = 3'd1;
        end
      end
      WAIT_BAT: begin
        timer_d = timer_inc;
        if (tx_error) begin
          fail = 1'b1; fail_code = 3'd4;
        end else if (rx_valid) begin
          if (rx_byte == 8'hAA) begin
            state_d = WAIT_ID;
            timer_d = '0;
          end else begin
            fail = 1'b1; fail_code = (rx_byte == 8'hFC) ? 3'd3 : 3'd2;
          end
        end else if (timer_q >= BAT_LIM) begin
          fail = 1'b1; fail_code = 3'd5;
        end
      end
      WAIT_ID: begin
        timer_d = timer_inc;
        if (tx_error) begin
          fail = 1'b1; fail_code = 3'd4;
        end else if (rx_valid) begin
          if (rx_byte == 8'h00) begin
            state_d = SEND;
            step_d  = 2'd1;
          end else begin
            fail = 1'b1; fail_code = 3'd2;
          end
        end else if (timer_q >= ACK_LIM) begin
          fail = 1'b1; fail_code = 3'd1;
        end
      end
      RUN: begin
        idx_d = idx_eff;
        gap_d = (idx_eff == 2'd0) ? '0 : ((gap_q == {GW{1'b1}}) ? gap_q : gap_q + 1'b1);
        if (rx_valid) begin
          gap_d = '0;
          case (idx_eff)
            2'd0: begin
              if (rx_byte[3]) begin
                b0_d  = rx_byte;
                idx_d = 2'd1;
              end
            end
            2'd1: begin
              b1_d  = rx_byte;
              idx_d = 2'd2;
            end
            default: begin
              pkt_valid_d   = 1'b1;
              pkt_buttons_d = b0_q[2:0];
              pkt_dx_d      = {b0_q[4], b1_q};
              pkt_dy_d      = {b0_q[5], rx_byte};
              pkt_ovf_d     = b0_q[7:6];
              idx_d         = 2'd0;
            end
          endcase
        end
      end
      default: ;
    endcase

    if (fail) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 1'b1;
        step_d  = 2'd0;
        state_d = SEND;
      end else begin
        state_d    = ERROR;
        error_d    = 1'b1;
        err_code_d = fail_code;
      end
    end

    // Restart overrides everything, including a byte arriving this cycle.
    if (start) begin
      state_d    = SEND;
      step_d     = 2'd0;
      retry_d    = '0;
      timer_d    = '0;
      error_d    = 1'b0;
      err_code_d = 3'd0;
      idx_d      = 2'd0;
      gap_d      = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      step_q        <= 2'd0;
      retry_q       <= '0;
      timer_q       <= '0;
      gap_q         <= '0;
      error_q       <= 1'b0;
      err_code_q    <= 3'd0;
      idx_q         <= 2'd0;
      b0_q          <= 8'h00;
      b1_q          <= 8'h00;
      pkt_valid_q   <= 1'b0;
      pkt_buttons_q <= 3'd0;
      pkt_dx_q      <= 9'd0;
      pkt_dy_q      <= 9'd0;
      pkt_ovf_q     <= 2'd0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      retry_q       <= retry_d;
      timer_q       <= timer_d;
      gap_q         <= gap_d;
      error_q       <= error_d;
      err_code_q    <= err_code_d;
      idx_q         <= idx_d;
      b0_q          <= b0_d;
      b1_q          <= b1_d;
      pkt_valid_q   <= pkt_valid_d;
      pkt_buttons_q <= pkt_buttons_d;
      pkt_dx_q      <= pkt_dx_d;
      pkt_dy_q      <= pkt_dy_d;
      pkt_ovf_q     <= pkt_ovf_d;
    end
  end

  assign tx_valid    = (state_q == SEND);
  assign tx_byte     = (state_q == SEND) ? rom_byte : 8'h00;
  assign busy        = (state_q == SEND) || (state_q == WAIT_ACK) ||
                       (state_q == WAIT_BAT) || (state_q == WAIT_ID);
  assign ready       = (state_q == RUN);
  assign error       = error_q;
  assign err_code    = err_code_q;
  assign pkt_valid   = pkt_valid_q;
  assign pkt_buttons = pkt_buttons_q;
  assign pkt_dx      = pkt_dx_q;
  assign pkt_dy      = pkt_dy_q;
  assign pkt_ovf     = pkt_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_init_sequencer.sv
// ============================================================================
//  Module   : tb_ps2_init_sequencer
//  Brief    : Directed bench: init handshakes, retry/timeout paths, packet table.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_init_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       start    = 1'b0;
  logic       tx_ready = 1'b0;
  logic       tx_error = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte  = 8'h00;
  logic       tx_valid, busy, ready, error, pkt_valid;
  logic [7:0] tx_byte;
  logic [2:0] err_code, pkt_buttons;
  logic [8:0] pkt_dx, pkt_dy;
  logic [1:0] pkt_ovf;

  int n_chk  = 0;
  int n_fail = 0;
  int pkt_cnt = 0;
  int tx_seen = 0;

  ps2_init_sequencer #(
    .SAMPLE_RATE(100), .ACK_TIMEOUT(40), .BAT_TIMEOUT(80), .PKT_GAP(30), .MAX_RETRY(3)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready), .tx_error(tx_error),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .busy(busy), .ready(ready), .error(error), .err_code(err_code),
    .pkt_valid(pkt_valid), .pkt_buttons(pkt_buttons), .pkt_dx(pkt_dx),
    .pkt_dy(pkt_dy), .pkt_ovf(pkt_ovf)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (pkt_valid) pkt_cnt++;
    if (tx_valid)  tx_seen++;
  end

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic [2:0] btn;
    logic [8:0] dx, dy;
    logic [1:0] ovf;
  } pkt_vec_t;

  pkt_vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
  endtask

  // Waits for a command byte, checks it, and accepts it with one tx_ready cycle.
  task automatic expect_tx(input logic [7:0] exp, input string nm);
    int cyc = 0;
    while (!tx_valid && cyc < 200) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    if (!tx_valid) begin
      chk({nm, "_timeout"}, 32'(tx_valid), 32'd1);
    end else begin
      chk(nm, 32'(tx_byte), 32'(exp));
      tx_ready = 1'b1;
      @(negedge CLOCK_50);
      tx_ready = 1'b0;
    end
  endtask

  task automatic full_init();
    pulse_start();
    expect_tx(8'hFF, "init_ff");
    send_rx(8'hFA); send_rx(8'hAA); send_rx(8'h00);
    expect_tx(8'hF3, "init_f3");
    send_rx(8'hFA);
    expect_tx(8'h64, "init_rate");
    send_rx(8'hFA);
    expect_tx(8'hF4, "init_f4");
    send_rx(8'hFA);
  endtask

  initial begin
    vecs[0] = '{8'h29, 8'h05, 8'hF0, 3'b001, 9'h005, 9'h1F0, 2'b00};
    vecs[1] = '{8'h19, 8'h05, 8'hF0, 3'b001, 9'h105, 9'h0F0, 2'b00};
    vecs[2] = '{8'hCF, 8'h80, 8'h7F, 3'b111, 9'h080, 9'h07F, 2'b11};
    vecs[3] = '{8'h3A, 8'hFF, 8'hFF, 3'b010, 9'h1FF, 9'h1FF, 2'b00};
    vecs[4] = '{8'h4C, 8'h00, 8'h01, 3'b100, 9'h000, 9'h001, 2'b01};

    repeat (3) @(negedge CLOCK_50);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_busy",     32'(busy), 0);
    chk("rst_ready",    32'(ready), 0);
    chk("rst_error",    32'(error), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_pkt",      32'({pkt_valid, pkt_dx, pkt_dy}), 0);
    reset_n = 1'b1;
    @(negedge CLOCK_50);

    // Normal bring-up.
    full_init();
    chk("init_ready", 32'(ready), 1);
    chk("init_busy",  32'(busy), 0);
    chk("init_error", 32'(error), 0);

    // Packet table while streaming.
    for (int i = 0; i < 5; i++) begin
      send_rx(vecs[i].b0); send_rx(vecs[i].b1); send_rx(vecs[i].b2);
      chk($sformatf("pkt%0d_valid", i),   32'(pkt_valid), 1);
      chk($sformatf("pkt%0d_buttons", i), 32'(pkt_buttons), 32'(vecs[i].btn));
      chk($sformatf("pkt%0d_dx", i),      32'(pkt_dx), 32'(vecs[i].dx));
      chk($sformatf("pkt%0d_dy", i),      32'(pkt_dy), 32'(vecs[i].dy));
      chk($sformatf("pkt%0d_ovf", i),     32'(pkt_ovf), 32'(vecs[i].ovf));
      @(negedge CLOCK_50);
      chk($sformatf("pkt%0d_pulse", i),   32'(pkt_valid), 0);
    end

    // Resync on bit3=0, then gap expiry drops a partial packet.
    pkt_cnt = 0;
    send_rx(8'h02); send_rx(8'h08); send_rx(8'h01);
    repeat (40) @(negedge CLOCK_50);
    send_rx(8'h08); send_rx(8'h02); send_rx(8'h03);
    @(negedge CLOCK_50);
    chk("resync_count", 32'(pkt_cnt), 1);
    chk("resync_dx",    32'(pkt_dx), 32'h002);
    chk("resync_dy",    32'(pkt_dy), 32'h003);
    chk("resync_btn",   32'(pkt_buttons), 0);

    // Resend request on step 1.
    pulse_start();
    chk("restart_ready", 32'(ready), 0);
    expect_tx(8'hFF, "rs_ff");
    send_rx(8'hFA); send_rx(8'hAA); send_rx(8'h00);
    expect_tx(8'hF3, "rs_f3_first");
    send_rx(8'hFE);
    expect_tx(8'hF3, "rs_f3_again");
    send_rx(8'hFA);
    expect_tx(8'h64, "rs_rate");
    send_rx(8'hFA);
    expect_tx(8'hF4, "rs_f4");
    send_rx(8'hFA);
    chk("rs_ready", 32'(ready), 1);

    // BAT failure exhausts retries: four attempts, then ERROR code 3.
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      expect_tx(8'hFF, $sformatf("bat_try%0d", i));
      send_rx(8'hFA);
      send_rx(8'hFC);
    end
    tx_seen = 0;
    repeat (50) @(negedge CLOCK_50);
    chk("bat_error", 32'(error), 1);
    chk("bat_code",  32'(err_code), 3);
    chk("bat_busy",  32'(busy), 0);
    chk("bat_no_tx", 32'(tx_seen), 0);

    // Ack timeout: four silent attempts, then ERROR code 1.
    pulse_start();
    chk("to_error_cleared", 32'(error), 0);
    for (int i = 0; i < 4; i++) expect_tx(8'hFF, $sformatf("to_try%0d", i));
    tx_seen = 0;
    repeat (60) @(negedge CLOCK_50);
    chk("to_error", 32'(error), 1);
    chk("to_code",  32'(err_code), 1);
    chk("to_no_tx", 32'(tx_seen), 0);

    // Asynchronous reset while a command is offered.
    pulse_start();
    chk("ar_tx_valid_pre", 32'(tx_valid), 1);
    #3 reset_n = 1'b0;
    #1 chk("ar_tx_valid", 32'(tx_valid), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_error", 32'(error), 0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(negedge CLOCK_50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
